// File: rtl/aixh_mxc_left_ptile_pipe.sv
// Left processing tile: per-row skewed forward command pipe plus per-row backward result buffers
// drained through one arbitrated valid/ready port. Optional round-robin arbiter: AIXH_MXC_LEFT_PTILE_RR_EN.
module aixh_mxc_left_ptile_pipe #(
    parameter int TILE_INDEX = 0,
    parameter int YCELLS     = 4,
    parameter int CWIDTH     = 8,
    parameter int DWIDTH     = 64,
    parameter int RWIDTH     = 32,
    parameter int ROW_LAT    = 1,
    parameter int RBUF_DEPTH = 2
) (
    input  logic                        aixh_core_clk2x,
    input  logic                        aixh_core_rstn2x,
    input  logic [CWIDTH-1:0]           i_lpt_cmd,
    input  logic                        i_lpt_vld,
    input  logic [DWIDTH-1:0]           i_lpt_dat,
    output logic [CWIDTH-1:0]           o_lpt_cmd,
    output logic                        o_lpt_vld,
    output logic [DWIDTH-1:0]           o_lpt_dat,
    input  logic [YCELLS-1:0]           i_row_en,
    output logic [YCELLS-1:0]           o_ipt_vld,
    output logic [YCELLS*CWIDTH-1:0]    o_ipt_cmd,
    output logic [YCELLS*DWIDTH-1:0]    o_ipt_dat,
    input  logic [YCELLS-1:0]           i_ipt_vld,
    input  logic [YCELLS*RWIDTH-1:0]    i_ipt_dat,
    output logic [YCELLS-1:0]           o_ipt_full,
    output logic                        o_lqt_vld,
    output logic [$clog2(YCELLS)-1:0]   o_lqt_row,
    output logic [RWIDTH-1:0]           o_lqt_dat,
    input  logic                        i_lqt_rdy,
    output logic                        o_ovf,
    input  logic                        i_ovf_clr
);

    localparam int LAST = YCELLS * ROW_LAT;
    localparam int NSTG = LAST + 1;
    localparam int ROWW = $clog2(YCELLS);
    localparam int PTRW = $clog2(RBUF_DEPTH);
    localparam int CNTW = PTRW + 1;

    if (YCELLS < 2 || ROW_LAT < 0 || ROW_LAT > 1 || RBUF_DEPTH < 2 ||
        (RBUF_DEPTH & (RBUF_DEPTH - 1)) != 0 || TILE_INDEX < 0) begin : g_bad_param
        $error("aixh_mxc_left_ptile_pipe: illegal parameter set");
    end

    // ---------------- forward skew pipeline ----------------
    logic              r_vld_p [NSTG];
    logic [CWIDTH-1:0] r_cmd_p [NSTG];
    logic [DWIDTH-1:0] r_dat_p [NSTG];
    logic [YCELLS-1:0] r_row_en;

    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn2x) begin
        if (!aixh_core_rstn2x) begin
            r_row_en <= '0;
            for (int k = 0; k < NSTG; k++) begin
                r_vld_p[k] <= 1'b0;
                r_cmd_p[k] <= '0;
                r_dat_p[k] <= '0;
            end
        end else begin
            r_row_en   <= i_row_en;
            r_vld_p[0] <= i_lpt_vld;
            if (i_lpt_vld) begin
                r_cmd_p[0] <= i_lpt_cmd;
                r_dat_p[0] <= i_lpt_dat;
            end
            // idle slots keep the last command/data so rows see a stable bus
            for (int k = 1; k < NSTG; k++) begin
                r_vld_p[k] <= r_vld_p[k-1];
                if (r_vld_p[k-1]) begin
                    r_cmd_p[k] <= r_cmd_p[k-1];
                    r_dat_p[k] <= r_dat_p[k-1];
                end
            end
        end
    end

    for (genvar y = 0; y < YCELLS; y++) begin : g_row_out
        assign o_ipt_vld[y]                     = r_vld_p[y*ROW_LAT] & r_row_en[y];
        assign o_ipt_cmd[y*CWIDTH +: CWIDTH]    = r_cmd_p[y*ROW_LAT];
        assign o_ipt_dat[y*DWIDTH +: DWIDTH]    = r_dat_p[y*ROW_LAT];
    end

    assign o_lpt_vld = r_vld_p[LAST];
    assign o_lpt_cmd = r_cmd_p[LAST];
    assign o_lpt_dat = r_dat_p[LAST];

    // ---------------- backward result buffers ----------------
    logic [RWIDTH-1:0] r_buf  [YCELLS][RBUF_DEPTH];
    logic [PTRW-1:0]   r_wptr [YCELLS];
    logic [PTRW-1:0]   r_rptr [YCELLS];
    logic [CNTW-1:0]   r_cnt  [YCELLS];

    logic [YCELLS-1:0] w_full;
    logic [YCELLS-1:0] w_nempty;
    logic [YCELLS-1:0] w_req;
    logic [YCELLS-1:0] w_push;
    logic [YCELLS-1:0] w_drop;
    logic [YCELLS-1:0] w_pop;

    logic              w_load;
    logic              w_any;
    logic [ROWW-1:0]   w_sel;
    logic [RWIDTH-1:0] w_sel_dat;

    logic              r_lqt_vld;
    logic [ROWW-1:0]   r_lqt_row;
    logic [RWIDTH-1:0] r_lqt_dat;
    logic              r_ovf;

    // full comes from the registered count only, so a same-cycle pop cannot admit a write
    assign w_req  = i_ipt_vld & r_row_en;
    assign w_push = w_req & ~w_full;
    assign w_drop = w_req & w_full;

    for (genvar y = 0; y < YCELLS; y++) begin : g_row_flags
        assign w_full[y]   = (r_cnt[y] == CNTW'(RBUF_DEPTH));
        assign w_nempty[y] = (r_cnt[y] != '0);
        assign w_pop[y]    = w_load & w_any & (w_sel == ROWW'(y));
    end

    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn2x) begin
        if (!aixh_core_rstn2x) begin
            for (int y = 0; y < YCELLS; y++) begin
                r_wptr[y] <= '0;
                r_rptr[y] <= '0;
                r_cnt[y]  <= '0;
            end
        end else begin
            for (int y = 0; y < YCELLS; y++) begin
                if (w_push[y]) r_wptr[y] <= r_wptr[y] + 1'b1;
                if (w_pop[y])  r_rptr[y] <= r_rptr[y] + 1'b1;
                case ({w_push[y], w_pop[y]})
                    2'b10:   r_cnt[y] <= r_cnt[y] + 1'b1;
                    2'b01:   r_cnt[y] <= r_cnt[y] - 1'b1;
                    default: r_cnt[y] <= r_cnt[y];
                endcase
            end
        end
    end

    always_ff @(posedge aixh_core_clk2x) begin
        for (int y = 0; y < YCELLS; y++) begin
            if (w_push[y]) r_buf[y][r_wptr[y]] <= i_ipt_dat[y*RWIDTH +: RWIDTH];
        end
    end

    // ---------------- arbitration ----------------
    assign w_load = ~r_lqt_vld | i_lqt_rdy;

`ifdef AIXH_MXC_LEFT_PTILE_RR_EN
    logic [ROWW-1:0] r_rr_ptr;
    logic            w_lo_any;
    logic [ROWW-1:0] w_lo_sel;
    logic            w_hi_any;
    logic [ROWW-1:0] w_hi_sel;

    // lowest request at/after the pointer wins; otherwise wrap to the lowest request overall
    always_comb begin
        w_lo_any = 1'b0;
        w_lo_sel = '0;
        w_hi_any = 1'b0;
        w_hi_sel = '0;
        for (int y = YCELLS - 1; y >= 0; y--) begin
            if (w_nempty[y]) begin
                w_lo_any = 1'b1;
                w_lo_sel = ROWW'(y);
                if (y >= int'(r_rr_ptr)) begin
                    w_hi_any = 1'b1;
                    w_hi_sel = ROWW'(y);
                end
            end
        end
        w_any = w_lo_any;
        w_sel = w_hi_any ? w_hi_sel : w_lo_sel;
    end

    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn2x) begin
        if (!aixh_core_rstn2x) begin
            r_rr_ptr <= '0;
        end else if (w_load && w_any) begin
            r_rr_ptr <= (w_sel == ROWW'(YCELLS - 1)) ? '0 : w_sel + 1'b1;
        end
    end
`else
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int y = YCELLS - 1; y >= 0; y--) begin
            if (w_nempty[y]) begin
                w_any = 1'b1;
                w_sel = ROWW'(y);
            end
        end
    end
`endif

    always_comb begin
        w_sel_dat = '0;
        for (int y = 0; y < YCELLS; y++) begin
            if (w_sel == ROWW'(y)) w_sel_dat = r_buf[y][r_rptr[y]];
        end
    end

    // ---------------- output slot and overflow ----------------
    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn2x) begin
        if (!aixh_core_rstn2x) begin
            r_lqt_vld <= 1'b0;
            r_lqt_row <= '0;
            r_lqt_dat <= '0;
        end else if (w_load) begin
            r_lqt_vld <= w_any;
            if (w_any) begin
                r_lqt_row <= w_sel;
                r_lqt_dat <= w_sel_dat;
            end
        end
    end

    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn2x) begin
        if (!aixh_core_rstn2x) begin
            r_ovf <= 1'b0;
        end else if (|w_drop) begin
            r_ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign o_ipt_full = w_full;
    assign o_lqt_vld  = r_lqt_vld;
    assign o_lqt_row  = r_lqt_row;
    assign o_lqt_dat  = r_lqt_dat;
    assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_aixh_mxc_left_ptile_pipe.sv
// Bench for aixh_mxc_left_ptile_pipe: queue/history reference model compared every cycle,
// plus directed literal checks for stream skew, mask, backpressure, arbitration and reset.
module tb_aixh_mxc_left_ptile_pipe;
    localparam int YC    = 4;
    localparam int CW    = 8;
    localparam int DW    = 64;
    localparam int RW    = 32;
    localparam int RL    = 1;
    localparam int DEPTH = 2;
    localparam int ROWW  = $clog2(YC);
    localparam int MAXC  = 4096;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [CW-1:0]    i_lpt_cmd = '0;
    logic             i_lpt_vld = 1'b0;
    logic [DW-1:0]    i_lpt_dat = '0;
    logic [YC-1:0]    i_row_en  = '0;
    logic [YC-1:0]    i_ipt_vld = '0;
    logic [YC*RW-1:0] i_ipt_dat = '0;
    logic             i_lqt_rdy = 1'b0;
    logic             i_ovf_clr = 1'b0;

    logic [CW-1:0]    o_lpt_cmd;
    logic             o_lpt_vld;
    logic [DW-1:0]    o_lpt_dat;
    logic [YC-1:0]    o_ipt_vld;
    logic [YC*CW-1:0] o_ipt_cmd;
    logic [YC*DW-1:0] o_ipt_dat;
    logic [YC-1:0]    o_ipt_full;
    logic             o_lqt_vld;
    logic [ROWW-1:0]  o_lqt_row;
    logic [RW-1:0]    o_lqt_dat;
    logic             o_ovf;

    always #5 clk = ~clk;

    aixh_mxc_left_ptile_pipe #(
        .TILE_INDEX(0), .YCELLS(YC), .CWIDTH(CW), .DWIDTH(DW),
        .RWIDTH(RW), .ROW_LAT(RL), .RBUF_DEPTH(DEPTH)
    ) dut (
        .aixh_core_clk2x (clk),
        .aixh_core_rstn2x(rst_n),
        .i_lpt_cmd (i_lpt_cmd),
        .i_lpt_vld (i_lpt_vld),
        .i_lpt_dat (i_lpt_dat),
        .o_lpt_cmd (o_lpt_cmd),
        .o_lpt_vld (o_lpt_vld),
        .o_lpt_dat (o_lpt_dat),
        .i_row_en  (i_row_en),
        .o_ipt_vld (o_ipt_vld),
        .o_ipt_cmd (o_ipt_cmd),
        .o_ipt_dat (o_ipt_dat),
        .i_ipt_vld (i_ipt_vld),
        .i_ipt_dat (i_ipt_dat),
        .o_ipt_full(o_ipt_full),
        .o_lqt_vld (o_lqt_vld),
        .o_lqt_row (o_lqt_row),
        .o_lqt_dat (o_lqt_dat),
        .i_lqt_rdy (i_lqt_rdy),
        .o_ovf     (o_ovf),
        .i_ovf_clr (i_ovf_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int            n = 0;
    logic          h_vld [MAXC];
    logic [CW-1:0] h_cmd [MAXC];
    logic [DW-1:0] h_dat [MAXC];
    logic [YC-1:0] h_en  [MAXC];
    logic [RW-1:0] mq [YC][$];
    logic          m_vld = 1'b0;
    logic [ROWW-1:0] m_row = '0;
    logic [RW-1:0] m_dat = '0;
    int            m_ptr = 0;
    logic          m_ovf = 1'b0;
    logic [YC-1:0] m_en  = '0;

    task automatic model_reset();
        n = 0;
        h_vld[0] = 1'b0;
        h_cmd[0] = '0;
        h_dat[0] = '0;
        h_en[0]  = '0;
        for (int y = 0; y < YC; y++) mq[y].delete();
        m_vld = 1'b0;
        m_row = '0;
        m_dat = '0;
        m_ptr = 0;
        m_ovf = 1'b0;
        m_en  = '0;
    endtask

    task automatic model_edge();
        int  sz [YC];
        int  pick;
        int  yy;
        logic set;
        if (n >= MAXC - 1) begin
            $display("FAIL model_history: cycle index %0d, limit %0d", n, MAXC - 1);
            $fatal(1, "history exhausted");
        end
        n++;
        h_vld[n] = i_lpt_vld;
        h_cmd[n] = i_lpt_vld ? i_lpt_cmd : h_cmd[n-1];
        h_dat[n] = i_lpt_vld ? i_lpt_dat : h_dat[n-1];
        h_en[n]  = i_row_en;
        for (int y = 0; y < YC; y++) sz[y] = mq[y].size();
        if (!m_vld || i_lqt_rdy) begin
            pick = -1;
            for (int i = 0; i < YC; i++) begin
`ifdef AIXH_MXC_LEFT_PTILE_RR_EN
                yy = (m_ptr + i) % YC;
`else
                yy = i;
`endif
                if (pick < 0 && sz[yy] > 0) pick = yy;
            end
            if (pick >= 0) begin
                m_vld = 1'b1;
                m_row = ROWW'(pick);
                m_dat = mq[pick].pop_front();
                m_ptr = (pick + 1) % YC;
            end else begin
                m_vld = 1'b0;
            end
        end
        set = 1'b0;
        for (int y = 0; y < YC; y++) begin
            if (i_ipt_vld[y] && m_en[y]) begin
                if (sz[y] == DEPTH) set = 1'b1;
                else mq[y].push_back(i_ipt_dat[y*RW +: RW]);
            end
        end
        m_ovf = set ? 1'b1 : (i_ovf_clr ? 1'b0 : m_ovf);
        m_en  = i_row_en;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_edge();
    end

    // ---------------- per-cycle compare ----------------
    task automatic compare_all();
        logic [YC-1:0] ev;
        logic [YC-1:0] ef;
        int idx;
        ev = '0;
        ef = '0;
        for (int y = 0; y < YC; y++) begin
            idx = n - y * RL;
            ev[y] = (idx >= 1) ? (h_vld[idx] & h_en[n][y]) : 1'b0;
            ef[y] = (mq[y].size() == DEPTH);
            chk($sformatf("ipt_cmd[%0d]", y), o_ipt_cmd[y*CW +: CW], (idx >= 1) ? h_cmd[idx] : '0);
            chk($sformatf("ipt_dat[%0d]", y), o_ipt_dat[y*DW +: DW], (idx >= 1) ? h_dat[idx] : '0);
        end
        chk("ipt_vld", o_ipt_vld, ev);
        idx = n - YC * RL;
        chk("lpt_vld", o_lpt_vld, (idx >= 1) ? h_vld[idx] : 1'b0);
        chk("lpt_cmd", o_lpt_cmd, (idx >= 1) ? h_cmd[idx] : '0);
        chk("lpt_dat", o_lpt_dat, (idx >= 1) ? h_dat[idx] : '0);
        chk("ipt_full", o_ipt_full, ef);
        chk("lqt_vld", o_lqt_vld, m_vld);
        if (m_vld) begin
            chk("lqt_row", o_lqt_row, m_row);
            chk("lqt_dat", o_lqt_dat, m_dat);
        end
        chk("ovf", o_ovf, m_ovf);
    endtask

    always @(negedge clk) compare_all();

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded 500000 time units");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_in();
        i_lpt_vld = 1'b0;
        i_ipt_vld = '0;
        i_ovf_clr = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_lpt_vld"}, o_lpt_vld, 0);
        chk({tag, "_lpt_cmd"}, o_lpt_cmd, 0);
        chk({tag, "_lpt_dat"}, o_lpt_dat, 0);
        chk({tag, "_ipt_vld"}, o_ipt_vld, 0);
        chk({tag, "_ipt_cmd"}, o_ipt_cmd, 0);
        chk({tag, "_ipt_full"}, o_ipt_full, 0);
        chk({tag, "_lqt_vld"}, o_lqt_vld, 0);
        chk({tag, "_lqt_row"}, o_lqt_row, 0);
        chk({tag, "_lqt_dat"}, o_lqt_dat, 0);
        chk({tag, "_ovf"}, o_ovf, 0);
    endtask

    logic [YC-1:0]   exp_v;
    logic [ROWW-1:0] got_rows [$];
    logic [ROWW-1:0] exp_seq [6];

    initial begin
        // reset state
        repeat (3) cyc();
        chk_all_zero("reset");
        rst_n = 1'b1;

        // single beat skew through the rows
        i_row_en  = '1;
        i_lqt_rdy = 1'b1;
        cyc();
        i_lpt_vld = 1'b1;
        i_lpt_cmd = 8'h5A;
        i_lpt_dat = 64'h1234;
        cyc();
        i_lpt_vld = 1'b0;
        i_lpt_cmd = 8'hC3;
        i_lpt_dat = 64'hDEAD;
        for (int t = 1; t <= YC + 1; t++) begin
            if (t > 1) cyc();
            exp_v = (t <= YC) ? YC'(1 << (t - 1)) : '0;
            chk($sformatf("stream_vld_t%0d", t), o_ipt_vld, exp_v);
            chk($sformatf("stream_lpt_vld_t%0d", t), o_lpt_vld, (t == YC + 1) ? 1'b1 : 1'b0);
            if (t <= YC) begin
                chk($sformatf("stream_cmd_t%0d", t), o_ipt_cmd[(t-1)*CW +: CW], 8'h5A);
                chk($sformatf("stream_dat_t%0d", t), o_ipt_dat[(t-1)*DW +: DW], 64'h1234);
            end else begin
                chk("stream_lpt_cmd", o_lpt_cmd, 8'h5A);
                chk("stream_lpt_dat", o_lpt_dat, 64'h1234);
            end
        end

        // row mask 1011 with continuous beats and row-2 results
        i_row_en = 4'b1011;
        cyc();
        for (int t = 0; t < 40; t++) begin
            i_lpt_vld = 1'b1;
            i_lpt_cmd = CW'($urandom);
            i_lpt_dat = {$urandom, $urandom};
            i_ipt_vld = (t % 2 == 0) ? 4'b0100 : 4'b0000;
            i_ipt_dat = {$urandom, $urandom, $urandom, $urandom};
            cyc();
            chk("mask_row2_vld", o_ipt_vld[2], 1'b0);
            if (t >= YC) chk("mask_lpt_vld", o_lpt_vld, 1'b1);
        end
        idle_in();
        repeat (6) cyc();
        chk("mask_no_ovf", o_ovf, 1'b0);
        chk("mask_no_result", o_lqt_vld, 1'b0);

        // backpressure on row 1
        i_row_en  = '1;
        i_lqt_rdy = 1'b0;
        cyc();
        for (int k = 0; k < 3; k++) begin
            i_ipt_vld = 4'b0010;
            i_ipt_dat = '0;
            i_ipt_dat[RW +: RW] = 32'h111 * (k + 1);
            cyc();
        end
        idle_in();
        cyc();
        chk("bp_full1", o_ipt_full[1], 1'b1);
        chk("bp_lqt_vld", o_lqt_vld, 1'b1);
        chk("bp_lqt_row", o_lqt_row, 1);
        chk("bp_lqt_dat", o_lqt_dat, 32'h111);
        chk("bp_ovf_before", o_ovf, 1'b0);
        i_ipt_vld = 4'b0010;
        i_ipt_dat[RW +: RW] = 32'h444;
        i_ovf_clr = 1'b1;
        cyc();
        idle_in();
        chk("bp_ovf_set_wins", o_ovf, 1'b1);
        chk("bp_full_after_drop", o_ipt_full[1], 1'b1);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_row", o_lqt_row, 1);
            chk("stall_dat", o_lqt_dat, 32'h111);
            chk("stall_ovf_sticky", o_ovf, 1'b1);
        end
        i_lqt_rdy = 1'b1;
        cyc();
        i_lqt_rdy = 1'b0;
        chk("pop_dat", o_lqt_dat, 32'h222);
        chk("pop_full1", o_ipt_full[1], 1'b0);
        cyc();
        chk("one_pop_dat", o_lqt_dat, 32'h222);
        i_ovf_clr = 1'b1;
        cyc();
        i_ovf_clr = 1'b0;
        chk("ovf_clr", o_ovf, 1'b0);
        i_lqt_rdy = 1'b1;
        repeat (5) cyc();

        // asynchronous reset with beats and results in flight
        i_lqt_rdy = 1'b0;
        i_ipt_vld = 4'hF;
        i_ipt_dat = {$urandom, $urandom, $urandom, $urandom};
        i_lpt_vld = 1'b1;
        i_lpt_cmd = 8'h77;
        cyc();
        i_ipt_vld = 4'b0011;
        i_ipt_dat = {$urandom, $urandom, $urandom, $urandom};
        cyc();
        i_ipt_vld = '0;
        cyc();
        idle_in();
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        cyc();
        cyc();
        rst_n = 1'b1;
        i_lqt_rdy = 1'b1;
        for (int t = 0; t < 12; t++) begin
            cyc();
            chk("post_rst_lqt_vld", o_lqt_vld, 1'b0);
            chk("post_rst_lpt_vld", o_lpt_vld, 1'b0);
        end

        // arbitration order with rows 0, 2 and 3 holding two results each
`ifdef AIXH_MXC_LEFT_PTILE_RR_EN
        exp_seq = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
`else
        exp_seq = '{2'd0, 2'd0, 2'd2, 2'd2, 2'd3, 2'd3};
`endif
        i_row_en = '1;
        cyc();
        for (int k = 0; k < 2; k++) begin
            i_ipt_vld = 4'b1101;
            i_ipt_dat = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end
        idle_in();
        for (int t = 0; t < 12; t++) begin
            if (o_lqt_vld) got_rows.push_back(o_lqt_row);
            cyc();
        end
        chk("arb_count", got_rows.size(), 6);
        for (int i = 0; i < 6 && i < got_rows.size(); i++)
            chk($sformatf("arb_row[%0d]", i), got_rows[i], exp_seq[i]);

        // randomized traffic on every port
        for (int t = 0; t < 800; t++) begin
            i_lpt_vld = 1'($urandom_range(0, 1));
            i_lpt_cmd = CW'($urandom);
            i_lpt_dat = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) i_row_en = YC'($urandom);
            i_ipt_vld = YC'($urandom) & YC'($urandom);
            i_ipt_dat = {$urandom, $urandom, $urandom, $urandom};
            i_lqt_rdy = ($urandom_range(0, 3) != 0);
            i_ovf_clr = ($urandom_range(0, 31) == 0);
            cyc();
        end
        idle_in();
        i_lqt_rdy = 1'b1;
        repeat (10) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
